mem_lsu: RTL and testbench
==========================

# mem_lsu

Parametrised, multi-cycle load/store unit for the MEM stage of the dcpu pipeline. It replaces single-cycle combinational data-memory access with a registered request/acknowledge bus transaction. It supports byte/half/word/64-bit transfers on a configurable data-bus width, splits misaligned scalar accesses into two beats, and raises pipeline exceptions on alignment faults and bus timeouts. It sits between the EX/MEM latch and data memory, and stalls the pipeline while a transaction is in flight.

## Interface
- AW, 32, address width
- DW, 32, data-bus width; legal values 32 or 64
- TIMEOUT, 255, wait cycles without `dm_ack` before a bus fault; range 1..255
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  MEM operation present
- req_ready  out  1  unit can accept an operation (IDLE only)
- req_op  in  3  0 NONE, 1 LOAD, 2 STORE, 3 LOAD64, 4 STORE64, others treated as NONE
- req_size  in  2  0 byte, 1 half, 2 word; ignored for 64-bit ops
- req_addr  in  AW  byte address
- req_wdata  in  64  store data, right-justified
- req_wd / req_wreg  in  5 / 1  destination register / write enable
- flush  in  1  abort current operation
- stall_o  out  1  hold upstream stages
- dm_ce, dm_we  out  1  bus request, write strobe
- dm_addr  out  AW  DW/8-aligned beat address
- dm_sel  out  DW/8  byte-lane enables
- dm_data_o  out  DW  lane-positioned write data
- dm_data_i  in  DW  read data, valid with `dm_ack`
- dm_ack  in  1  beat complete
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  64  load result, zero-extended
- resp_wd / resp_wreg  out  5 / 1  forwarded destination; `resp_wreg` = latched req_wreg AND op is a load
- exp_fl  out  1  one-cycle exception pulse
- exp_no  out  8  exception number
- exp_addr  out  AW  faulting request address

## Operation
- States:
  - IDLE: `req_ready`=1. An op is accepted when `req_valid`=1, op≠NONE, and `flush`=0. Op, addr, size, wdata, wd, and wreg are latched.
  - CHECK: alignment test and beat planning; lasts one cycle.
  - BUS: `dm_ce`=1.
  - DONE: drives `resp_valid` or `exp_fl` for one cycle, then returns to IDLE.
- A NONE op in IDLE passes through with no activity and no response.
- Byte count: n = 1/2/4/8. off = addr mod (DW/8).
- 64-bit ops with addr[1:0]≠0 → no bus activity. DONE with `exp_fl`=1, `exp_no`=8'h11.
- Beats: 1 if off+n ≤ DW/8, else 2.
  - Beat 0: `dm_addr` = aligned addr; `dm_sel` lanes off..min(off+n-1, DW/8-1).
  - Beat 1: `dm_addr` = aligned addr + DW/8; `dm_sel` lanes 0..(off+n-1-DW/8).
- DW=32, 64-bit aligned op: always 2 beats, low word first.
- Store data is shifted left by off bytes across the concatenated beats. Load bytes are assembled little-endian into `resp_data[8n-1:0]`; upper bits are 0.
- Timeout counter resets at each beat start and increments each BUS cycle without `dm_ack`. On reaching TIMEOUT: drop `dm_ce`, DONE with `exp_no`=8'h0D. A store's completed beat 0 is not rolled back.
- `flush`=1 in any state → IDLE next cycle, `dm_ce`=0, no `resp_valid`/`exp_fl`. Flush has priority over `dm_ack` in the same cycle.
- `stall_o` = (state≠IDLE) OR (`req_valid` AND op≠NONE AND state=IDLE AND NOT `flush`).

## Timing
- Reset (`rst`=0 at an edge): state IDLE, `req_ready`=1. All other outputs 0, including `dm_*`, `resp_*`, `exp_*`, `stall_o`, and the counter.
- All outputs are registered except `req_ready` and `stall_o`, which are decoded from state and inputs.
- Accept at edge T. CHECK T+1. `dm_ce` high from T+2.
- Bus signals hold stable until the edge where `dm_ack`=1. The next beat's address/sel/data are driven the following cycle with `dm_ce` kept high. `dm_ce` drops the cycle after the last ack.
- Zero-wait single beat: accept T, bus T+2, ack T+2, `resp_valid` T+3, next accept T+3.
- Each extra beat or wait state adds one cycle.
- `dm_ack` outside BUS is ignored.

## Test plan
- DW=32, LOAD word 0x1000, mem=0xDEADBEEF, zero-wait ack → one beat, `dm_sel`=4'b1111. `resp_valid` at T+3 with `resp_data`=0x00000000_DEADBEEF, `resp_wreg`=1.
- LOAD word 0x1003, words 0x44332211 @0x1000 and 0x88776655 @0x1004 → beats sel 4'b1000 then 4'b0111, `resp_data`=0x77665544.
- STORE half 0x2003, data 0xBEEF → beat 0: sel 4'b1000, data[31:24]=0xEF. Beat 1: addr 0x2004, sel 4'b0001, data[7:0]=0xBE. `resp_wreg`=0.
- STORE64 0x3000, data 0x11223344_55667788 → two beats writing 0x55667788 then 0x11223344. LOAD64 0x3002 → `exp_fl`, `exp_no`=8'h11, `exp_addr`=0x3002, `dm_ce` never high.
- TIMEOUT=4, `dm_ack` held low → `dm_ce` high exactly 4 cycles, then `exp_no`=8'h0D. `resp_valid` never asserts.
- `flush` asserted during beat 1 of a split load, coincident with `dm_ack` → `dm_ce` low next cycle, no `resp_valid`, `req_ready`=1. Reset asserted mid-BUS gives the same outcome with all outputs 0.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu - multi-cycle load/store unit for the dcpu MEM stage.
//
// Takes one memory operation from the EX/MEM latch and runs it on a
// request/acknowledge data bus. Misaligned scalar accesses are split into
// two beats. 64-bit ops that are not word aligned fault without touching
// the bus. A beat that waits TIMEOUT cycles for dm_ack raises a bus fault.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   req_*               operation from the pipeline; req_ready high in IDLE
//   flush               abort whatever is in flight, back to IDLE
//   stall_o             hold upstream stages while an op is pending
//   dm_*                data bus: request, write strobe, beat address,
//                       byte lanes, write data, read data, acknowledge
//   resp_*              one-cycle completion pulse, load data, dest reg
//   exp_*               one-cycle exception pulse, cause, faulting address
//   dbg_state           current FSM state (IDLE=0 CHECK=1 BUS=2 DONE=3)
//
// Handshakes:
//   req: an op transfers on a rising edge where req_valid=1, req_ready=1,
//        req_op is LOAD/STORE/LOAD64/STORE64 and flush=0. req_ready depends
//        only on state, so the requester may hold req_valid until it sees
//        the transfer.
//   dm:  a beat transfers on a rising edge where dm_ce=1 and dm_ack=1.
//        dm_addr/dm_sel/dm_data_o/dm_we are stable from the cycle dm_ce
//        rises until that edge; dm_data_i is sampled on that edge.
module mem_lsu #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [1:0]        req_size,
  input  logic [AW-1:0]     req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [4:0]        req_wd,
  input  logic              req_wreg,
  input  logic              flush,
  output logic              stall_o,
  output logic              dm_ce,
  output logic              dm_we,
  output logic [AW-1:0]     dm_addr,
  output logic [DW/8-1:0]   dm_sel,
  output logic [DW-1:0]     dm_data_o,
  input  logic [DW-1:0]     dm_data_i,
  input  logic              dm_ack,
  output logic              resp_valid,
  output logic [63:0]       resp_data,
  output logic [4:0]        resp_wd,
  output logic              resp_wreg,
  output logic              exp_fl,
  output logic [7:0]        exp_no,
  output logic [AW-1:0]     exp_addr,
  output logic [1:0]        dbg_state
);

  localparam int NB   = DW / 8;
  localparam int OFFW = $clog2(NB);
  localparam int LW   = 2 * NB;   // lane mask across both beats
  localparam int W2   = 2 * DW;   // data across both beats

  localparam logic [7:0] EXC_ALIGN = 8'h11;
  localparam logic [7:0] EXC_BUS   = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_BUS   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_is_ld;
  logic              r_is_st;
  logic              r_is64;
  logic [1:0]        r_size;
  logic [AW-1:0]     r_addr;
  logic [63:0]       r_wdata;
  logic [4:0]        r_wd;
  logic              r_wreg;
  logic              r_beat;    // 0 = first beat, 1 = second beat
  logic [7:0]        r_cnt;     // wait cycles in the current beat
  logic [DW-1:0]     r_rlo;     // read data captured from beat 0

  logic              w_op_valid;
  logic [3:0]        w_n;
  logic [OFFW-1:0]   w_off;
  logic [4:0]        w_end;
  logic              w_two;
  logic              w_misal;
  logic [AW-1:0]     w_align;
  logic [LW-1:0]     w_lanes;
  logic [W2-1:0]     w_wcat;
  logic [W2-1:0]     w_rcat;
  logic [W2-1:0]     w_rsh;
  logic [63:0]       w_bmask;
  logic [63:0]       w_rdata;

  assign w_op_valid = (req_op >= 3'd1) && (req_op <= 3'd4);

  assign req_ready = (r_state == S_IDLE);
  assign stall_o   = (r_state != S_IDLE) ||
                     (req_valid && w_op_valid && !flush);
  assign dbg_state = r_state;

  // Transfer size in bytes; a size code of 3 is handled as a word.
  always_comb begin
    w_n = 4'd4;
    if (r_is64)               w_n = 4'd8;
    else if (r_size == 2'd0)  w_n = 4'd1;
    else if (r_size == 2'd1)  w_n = 4'd2;
  end

  assign w_off   = r_addr[OFFW-1:0];
  assign w_end   = 5'(w_off) + 5'(w_n);
  assign w_two   = (w_end > 5'(NB));
  assign w_misal = r_is64 && (r_addr[1:0] != 2'b00);
  assign w_align = {r_addr[AW-1:OFFW], {OFFW{1'b0}}};

  // n ones shifted to the start lane; for DW=32 an 8-byte op wraps the
  // shift to zero and the subtraction still yields all eight lanes.
  assign w_lanes = ((LW'(1) << w_n) - LW'(1)) << w_off;
  assign w_wcat  = W2'(r_wdata) << {w_off, 3'b000};

  // Read data as it stands on the edge of the final ack.
  assign w_rcat = r_beat ? {dm_data_i, r_rlo} : W2'(dm_data_i);
  assign w_rsh  = w_rcat >> {w_off, 3'b000};

  always_comb begin
    w_bmask = 64'h0000_0000_FFFF_FFFF;
    if (r_is64)              w_bmask = 64'hFFFF_FFFF_FFFF_FFFF;
    else if (w_n == 4'd1)    w_bmask = 64'h0000_0000_0000_00FF;
    else if (w_n == 4'd2)    w_bmask = 64'h0000_0000_0000_FFFF;
  end

  assign w_rdata = w_rsh[63:0] & w_bmask;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_is_ld    <= 1'b0;
      r_is_st    <= 1'b0;
      r_is64     <= 1'b0;
      r_size     <= 2'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wd       <= '0;
      r_wreg     <= 1'b0;
      r_beat     <= 1'b0;
      r_cnt      <= '0;
      r_rlo      <= '0;
      dm_ce      <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_sel     <= '0;
      dm_data_o  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_wd    <= '0;
      resp_wreg  <= 1'b0;
      exp_fl     <= 1'b0;
      exp_no     <= '0;
      exp_addr   <= '0;
    end else if (flush) begin
      // Abort wins over a coincident ack: the beat is simply dropped.
      r_state    <= S_IDLE;
      r_beat     <= 1'b0;
      r_cnt      <= '0;
      dm_ce      <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_sel     <= '0;
      dm_data_o  <= '0;
      resp_valid <= 1'b0;
      exp_fl     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          resp_valid <= 1'b0;
          exp_fl     <= 1'b0;
          if (req_valid && w_op_valid) begin
            r_is_ld <= (req_op == 3'd1) || (req_op == 3'd3);
            r_is_st <= (req_op == 3'd2) || (req_op == 3'd4);
            r_is64  <= (req_op == 3'd3) || (req_op == 3'd4);
            r_size  <= req_size;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wd    <= req_wd;
            r_wreg  <= req_wreg;
            r_state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_misal) begin
            exp_fl   <= 1'b1;
            exp_no   <= EXC_ALIGN;
            exp_addr <= r_addr;
            r_state  <= S_DONE;
          end else begin
            dm_ce     <= 1'b1;
            dm_we     <= r_is_st;
            dm_addr   <= w_align;
            dm_sel    <= w_lanes[NB-1:0];
            dm_data_o <= w_wcat[DW-1:0];
            r_beat    <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_BUS;
          end
        end

        S_BUS: begin
          if (dm_ack) begin
            if (!r_beat && w_two) begin
              // Beat 0 done; present beat 1 next cycle with dm_ce held.
              r_rlo     <= dm_data_i;
              r_beat    <= 1'b1;
              r_cnt     <= '0;
              dm_addr   <= w_align + AW'(NB);
              dm_sel    <= w_lanes[LW-1:NB];
              dm_data_o <= w_wcat[W2-1:DW];
            end else begin
              dm_ce      <= 1'b0;
              dm_we      <= 1'b0;
              dm_addr    <= '0;
              dm_sel     <= '0;
              dm_data_o  <= '0;
              resp_valid <= 1'b1;
              resp_data  <= r_is_ld ? w_rdata : 64'd0;
              resp_wd    <= r_wd;
              resp_wreg  <= r_wreg && r_is_ld;
              r_state    <= S_DONE;
            end
          end else if ((r_cnt + 8'd1) == 8'(TIMEOUT)) begin
            dm_ce     <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_sel    <= '0;
            dm_data_o <= '0;
            exp_fl    <= 1'b1;
            exp_no    <= EXC_BUS;
            exp_addr  <= r_addr;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_DONE: begin
          resp_valid <= 1'b0;
          exp_fl     <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu (DW=32, TIMEOUT=4) with a small word memory
// that acknowledges in the same cycle dm_ce is seen when ack_en=1.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [4:0]  req_wd = 5'd0;
  logic        req_wreg = 1'b0;
  logic        flush = 1'b0;
  logic        stall_o;
  logic        dm_ce, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_sel;
  logic [31:0] dm_data_o;
  logic [31:0] dm_data_i;
  logic        dm_ack;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic [4:0]  resp_wd;
  logic        resp_wreg;
  logic        exp_fl;
  logic [7:0]  exp_no;
  logic [31:0] exp_addr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int ce_cnt = 0;
  int rv_cnt = 0;
  int ef_cnt = 0;
  int lat;
  logic ack_en = 1'b1;

  logic [31:0] mem [0:7];
  logic [67:0] act_q[$];   // {addr, sel, write data (0 for loads)}
  logic [67:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_lsu #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wd(req_wd), .req_wreg(req_wreg), .flush(flush), .stall_o(stall_o),
    .dm_ce(dm_ce), .dm_we(dm_we), .dm_addr(dm_addr), .dm_sel(dm_sel),
    .dm_data_o(dm_data_o), .dm_data_i(dm_data_i), .dm_ack(dm_ack),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_wd(resp_wd),
    .resp_wreg(resp_wreg), .exp_fl(exp_fl), .exp_no(exp_no),
    .exp_addr(exp_addr), .dbg_state(dbg_state)
  );

  // Memory: 0x1000/0x1004 -> 2/3, 0x2000/0x2004 -> 4/5, 0x3000/0x3004 -> 6/7.
  assign dm_ack    = dm_ce & ack_en;
  assign dm_data_i = mem[{dm_addr[13:12], dm_addr[2]}];

  always @(posedge clk) begin
    if (dm_ce) ce_cnt++;
    if (resp_valid) rv_cnt++;
    if (exp_fl) ef_cnt++;
    if (dm_ce && dm_ack) begin
      act_q.push_back({dm_addr, dm_sel, dm_we ? dm_data_o : 32'd0});
      if (dm_we)
        for (int b = 0; b < 4; b++)
          if (dm_sel[b]) mem[{dm_addr[13:12], dm_addr[2]}][8*b +: 8] <= dm_data_o[8*b +: 8];
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_beats(input string tag);
    chk({tag, "_nbeats"}, 68'(act_q.size()), 68'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), act_q[i], exp_q[i]);
  endtask

  // ---------------- drivers ----------------
  task automatic do_req(input logic [2:0] op, input logic [1:0] size,
                        input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [4:0] wd, input logic wreg);
    @(negedge clk);
    act_q.delete();
    ce_cnt = 0; rv_cnt = 0; ef_cnt = 0;
    req_valid = 1'b1; req_op = op; req_size = size; req_addr = addr;
    req_wdata = wdata; req_wd = wd; req_wreg = wreg;
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 3'd0;
  endtask

  // Edges from the accept edge until resp_valid or exp_fl is seen.
  task automatic wait_resp(input string tag, output int l);
    l = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      l++;
      if (resp_valid || exp_fl) break;
    end
    chk({tag, "_responded"}, 68'(resp_valid | exp_fl), 68'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    mem[2] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 68'(req_ready), 68'd1);
    chk("rst_stall", 68'(stall_o), 68'd0);
    chk("rst_bus", {dm_ce, dm_we, dm_sel, dm_addr}, 68'd0);
    chk("rst_resp", {resp_valid, resp_wreg, resp_data}, 68'd0);
    chk("rst_exp", {exp_fl, exp_no, exp_addr}, 68'd0);
    chk("rst_state", 68'(dbg_state), 68'd0);
    @(negedge clk); rst = 1'b1;

    // stall_o decodes the pending request while still IDLE
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd1; flush = 1'b1;
    #1 chk("stall_flush_blocks", 68'(stall_o), 68'd0);
    flush = 1'b0;
    #1 chk("stall_pending", 68'(stall_o), 68'd1);
    req_op = 3'd0;
    #1 chk("stall_none_op", 68'(stall_o), 68'd0);
    req_valid = 1'b0;

    // Aligned word load, zero wait
    exp_q.delete();
    exp_q.push_back({32'h1000, 4'b1111, 32'd0});
    do_req(3'd1, 2'd2, 32'h1000, 64'd0, 5'd5, 1'b1);
    wait_resp("ldw", lat);
    chk("ldw_latency", 68'(lat), 68'd2);
    chk("ldw_data", 68'(resp_data), 68'h00000000_DEADBEEF);
    chk("ldw_wreg_wd", {resp_wreg, resp_wd}, {1'b1, 5'd5});
    chk_beats("ldw");
    @(posedge clk); #1;
    chk("ldw_pulse", 68'(resp_valid), 68'd0);

    // Misaligned word load, split into two beats
    mem[2] = 32'h44332211; mem[3] = 32'h88776655;
    exp_q.delete();
    exp_q.push_back({32'h1000, 4'b1000, 32'd0});
    exp_q.push_back({32'h1004, 4'b0111, 32'd0});
    do_req(3'd1, 2'd2, 32'h1003, 64'd0, 5'd7, 1'b1);
    wait_resp("ldw3", lat);
    chk("ldw3_latency", 68'(lat), 68'd3);
    chk("ldw3_data", 68'(resp_data), 68'h77665544);
    chk_beats("ldw3");

    // Byte and half loads, zero-extended
    do_req(3'd1, 2'd0, 32'h1001, 64'd0, 5'd1, 1'b1);
    wait_resp("ldb", lat);
    chk("ldb_data", 68'(resp_data), 68'h22);
    do_req(3'd1, 2'd1, 32'h1002, 64'd0, 5'd1, 1'b1);
    wait_resp("ldh", lat);
    chk("ldh_data", 68'(resp_data), 68'h4433);

    // Misaligned half store across a word boundary
    exp_q.delete();
    exp_q.push_back({32'h2000, 4'b1000, 32'hEF000000});
    exp_q.push_back({32'h2004, 4'b0001, 32'h000000BE});
    do_req(3'd2, 2'd1, 32'h2003, 64'h0000_0000_0000_BEEF, 5'd3, 1'b1);
    wait_resp("sth", lat);
    chk("sth_wreg", 68'(resp_wreg), 68'd0);
    chk_beats("sth");
    chk("sth_mem", {mem[4], mem[5]}, {32'hEF000000, 32'h000000BE});

    // 64-bit store, low word first
    exp_q.delete();
    exp_q.push_back({32'h3000, 4'b1111, 32'h55667788});
    exp_q.push_back({32'h3004, 4'b1111, 32'h11223344});
    do_req(3'd4, 2'd0, 32'h3000, 64'h11223344_55667788, 5'd0, 1'b0);
    wait_resp("sd", lat);
    chk("sd_valid", 68'(resp_valid), 68'd1);
    chk_beats("sd");

    // 64-bit load back
    do_req(3'd3, 2'd0, 32'h3000, 64'd0, 5'd9, 1'b1);
    wait_resp("ld64", lat);
    chk("ld64_data", 68'(resp_data), 68'h11223344_55667788);

    // 64-bit load at a non-word address: alignment fault, no bus
    do_req(3'd3, 2'd0, 32'h3002, 64'd0, 5'd9, 1'b1);
    wait_resp("ld64mis", lat);
    chk("ld64mis_exp", {exp_fl, exp_no, exp_addr}, {1'b1, 8'h11, 32'h3002});
    chk("ld64mis_valid", 68'(resp_valid), 68'd0);
    chk("ld64mis_ce", 68'(ce_cnt), 68'd0);

    // Bus timeout: ack withheld
    ack_en = 1'b0;
    do_req(3'd1, 2'd2, 32'h1000, 64'd0, 5'd2, 1'b1);
    wait_resp("tmo", lat);
    chk("tmo_exp", {exp_fl, exp_no, exp_addr}, {1'b1, 8'h0D, 32'h1000});
    chk("tmo_ce_cycles", 68'(ce_cnt), 68'd4);
    repeat (3) @(posedge clk); #1;
    chk("tmo_no_resp", 68'(rv_cnt), 68'd0);
    chk("tmo_ce_low", 68'(dm_ce), 68'd0);
    ack_en = 1'b1;

    // Flush on beat 1 of a split load, coincident with ack
    do_req(3'd1, 2'd2, 32'h1003, 64'd0, 5'd4, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dm_ce && dm_addr == 32'h1004) break;
    end
    chk("fl_beat1_seen", {dm_ce, dm_addr}, {1'b1, 32'h1004});
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_ce", 68'(dm_ce), 68'd0);
    chk("fl_ready", 68'(req_ready), 68'd1);
    repeat (3) @(posedge clk); #1;
    chk("fl_no_pulses", {32'(rv_cnt), 32'(ef_cnt)}, 68'd0);

    // Reset in the middle of a bus beat
    ack_en = 1'b0;
    do_req(3'd1, 2'd2, 32'h1000, 64'd0, 5'd6, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dm_ce) break;
    end
    chk("mrst_in_bus", 68'(dm_ce), 68'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_bus", {dm_ce, dm_we, dm_sel, dm_addr}, 68'd0);
    chk("mrst_wdata", 68'(dm_data_o), 68'd0);
    chk("mrst_resp", {resp_valid, resp_wreg, resp_wd, resp_data}, 68'd0);
    chk("mrst_exp", {exp_fl, exp_no, exp_addr}, 68'd0);
    chk("mrst_ready_stall", {req_ready, stall_o}, {1'b1, 1'b0});
    @(negedge clk); rst = 1'b1; ack_en = 1'b1;

    // Recovery after reset
    do_req(3'd1, 2'd0, 32'h1004, 64'd0, 5'd8, 1'b1);
    wait_resp("post", lat);
    chk("post_data", 68'(resp_data), 68'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
